// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multiport register file.
// The collision behaviour is selected by MULTIPORT_REGFILE_BYPASS_EN (see multiport_register_file).
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every register once after reset or on a clear request.
// Optional feature macro MULTIPORT_REGFILE_BYPASS_EN does not affect this block.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'((2 ** ADDR_W) - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              busy_q, busy_d;

  // Next-state logic: one entry per edge in CLEAR, wait for a request in IDLE
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    case (state_q)
      RF_CLEAR: begin
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d = RF_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = RF_CLEAR;
          busy_d  = 1'b1;
        end
      end
      RF_IDLE: begin
        if (clear_req) begin
          state_d   = RF_CLEAR;
          clr_idx_d = {ADDR_W{1'b0}};
          busy_d    = 1'b1;
        end else begin
          state_d   = RF_IDLE;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d   = RF_CLEAR;
        clr_idx_d = {ADDR_W{1'b0}};
        busy_d    = 1'b1;
      end
    endcase
  end

  // Sequencer state, restarts the walk from entry 0 on reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= {ADDR_W{1'b0}};
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign clr_we  = (state_q == RF_CLEAR);
  assign clr_idx = clr_idx_q;

endmodule

// File: rtl/multiport_register_file.sv
// Register file with N_RD registered read ports, one write port and a hardware clear walk.
// Define MULTIPORT_REGFILE_BYPASS_EN for write-first same-edge collisions; default is read-first.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear_req,
  input  logic                     enable_write,
  input  logic [ADDR_W-1:0]        RW,
  input  logic [DATA_W-1:0]        BusW,
  input  logic [N_RD-1:0]          rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic                     busy
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef MULTIPORT_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0]            mem_q [DEPTH];
  logic [N_RD-1:0][DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]            port_addr_s [N_RD];

  logic                         clr_we_s;
  logic [ADDR_W-1:0]            clr_idx_s;
  logic                         wr_en_s;
  logic [ADDR_W-1:0]            wr_addr_s;
  logic [DATA_W-1:0]            wr_data_s;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_we    (clr_we_s),
    .clr_idx   (clr_idx_s)
  );

  for (genvar g = 0; g < N_RD; g++) begin : g_port_addr
    assign port_addr_s[g] = rd_addr[g*ADDR_W +: ADDR_W];
  end

  // Write port mux: the clear walk owns the port; normal writes are dropped meanwhile
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = RW;
    wr_data_s = BusW;
    if (clr_we_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_idx_s;
      wr_data_s = {DATA_W{1'b0}};
    end else if (enable_write && !((ZERO_REG != 0) && (RW == ADDR_W'(0)))) begin
      wr_en_s   = 1'b1;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Storage array; contents are only zeroed by the clear walk, never by reset
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= wr_data_s;
    end
  end

  // Read port next values: forced to zero while clearing, held when the port is disabled
  always_comb begin
    rd_data_d = rd_data_q;
    for (int i = 0; i < N_RD; i++) begin
      if (clr_we_s) begin
        rd_data_d[i] = {DATA_W{1'b0}};
      end else if (rd_en[i]) begin
        if ((ZERO_REG != 0) && (port_addr_s[i] == ADDR_W'(0))) begin
          rd_data_d[i] = {DATA_W{1'b0}};
        end else if (BYPASS && enable_write && (RW == port_addr_s[i])) begin
          rd_data_d[i] = BusW;
        end else begin
          rd_data_d[i] = mem_q[port_addr_s[i]];
        end
      end else begin
        rd_data_d[i] = rd_data_q[i];
      end
    end
  end

  // Registered read data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule
